// File: rtl/mips_ctrl_alu_if.sv
// mips_ctrl_alu_if
// Bundles the decoder/ALU signals of mips_ctrl_alu.
//   slave  : the decoder/ALU side. It takes op, funct, srca and srcb,
//            and drives the control signals and the ALU results.
//   master : the instruction/operand side. It drives op, funct, srca and srcb,
//            and observes the control signals and the ALU results.
// Signal names match the datapath net names so the CPU top can connect by name.
interface mips_ctrl_alu_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        memtoreg;
  logic        memwrite;
  logic        branch;
  logic        alusrc;
  logic        regdst;
  logic        regwrite;
  logic        jump;
  logic [1:0]  aluop;
  logic [2:0]  alucontrol;
  logic [31:0] aluout;
  logic        zero;
  logic [31:0] aluout_q;
  logic        zero_q;

  modport slave (
    input  op, funct, srca, srcb,
    output memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump,
           aluop, alucontrol, aluout, zero, aluout_q, zero_q
  );

  modport master (
    output op, funct, srca, srcb,
    input  memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump,
           aluop, alucontrol, aluout, zero, aluout_q, zero_q
  );
endinterface

// File: rtl/mips_ctrl_alu.sv
// mips_ctrl_alu
// This module combines three blocks for the pipelined MIPS CPU:
//   - the main decoder,
//   - the ALU-control decoder,
//   - a 32-bit ALU with a single registered output stage.
// Ports:
//   clk   : rising-edge clock for the aluout_q/zero_q register
//   reset : asynchronous active-high; clears aluout_q and zero_q only
//   bus   : mips_ctrl_alu_if.slave
//           inputs  : op, funct, srca, srcb
//           outputs : decoded controls, aluout/zero (combinational),
//                     aluout_q/zero_q (registered)
module mips_ctrl_alu (
  input  logic              clk,
  input  logic              reset,
  mips_ctrl_alu_if.slave    bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [8:0]  ctrlBits;
  logic [1:0]  aluOp;
  logic [2:0]  aluCtrl;
  logic [31:0] aluResult;
  logic        aluZero;
  logic [31:0] aluOutReg;
  logic        zeroReg;

  // Packed as {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop}.
  // Unknown opcodes fall to all-zero so nothing writes state on garbage.
  always_comb begin
    ctrlBits = 9'b0_0_0_0_0_0_0_00;
    unique case (bus.op)
      OP_RTYPE: ctrlBits = 9'b1_1_0_0_0_0_0_10;
      OP_LW:    ctrlBits = 9'b1_0_1_0_0_1_0_00;
      OP_SW:    ctrlBits = 9'b0_0_1_0_1_0_0_00;
      OP_BEQ:   ctrlBits = 9'b0_0_0_1_0_0_0_01;
      OP_ADDI:  ctrlBits = 9'b1_0_1_0_0_0_0_00;
      OP_J:     ctrlBits = 9'b0_0_0_0_0_0_1_00;
      default:  ctrlBits = 9'b0_0_0_0_0_0_0_00;
    endcase
  end

  assign aluOp = ctrlBits[1:0];

  always_comb begin
    aluCtrl = 3'b010;
    if (aluOp == 2'b00) begin
      aluCtrl = 3'b010;
    end else if (aluOp == 2'b01) begin
      aluCtrl = 3'b110;
    end else begin
      unique case (bus.funct)
        FN_ADD:  aluCtrl = 3'b010;
        FN_SUB:  aluCtrl = 3'b110;
        FN_AND:  aluCtrl = 3'b000;
        FN_OR:   aluCtrl = 3'b001;
        FN_SLT:  aluCtrl = 3'b111;
        default: aluCtrl = 3'b010;
      endcase
    end
  end

  // slt uses a true signed compare rather than the sign of A-B,
  // so it stays correct when the subtraction overflows.
  always_comb begin
    aluResult = 32'd0;
    unique case (aluCtrl)
      3'b000: aluResult = bus.srca & bus.srcb;
      3'b001: aluResult = bus.srca | bus.srcb;
      3'b010: aluResult = bus.srca + bus.srcb;
      3'b011: aluResult = 32'd0;
      3'b100: aluResult = bus.srca & ~bus.srcb;
      3'b101: aluResult = bus.srca | ~bus.srcb;
      3'b110: aluResult = bus.srca - bus.srcb;
      3'b111: aluResult = ($signed(bus.srca) < $signed(bus.srcb)) ? 32'd1 : 32'd0;
      default: aluResult = 32'd0;
    endcase
  end

  assign aluZero = (aluResult == 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aluOutReg <= 32'd0;
      zeroReg   <= 1'b0;
    end else begin
      aluOutReg <= aluResult;
      zeroReg   <= aluZero;
    end
  end

  assign bus.regwrite   = ctrlBits[8];
  assign bus.regdst     = ctrlBits[7];
  assign bus.alusrc     = ctrlBits[6];
  assign bus.branch     = ctrlBits[5];
  assign bus.memwrite   = ctrlBits[4];
  assign bus.memtoreg   = ctrlBits[3];
  assign bus.jump       = ctrlBits[2];
  assign bus.aluop      = aluOp;
  assign bus.alucontrol = aluCtrl;
  assign bus.aluout     = aluResult;
  assign bus.zero       = aluZero;
  assign bus.aluout_q   = aluOutReg;
  assign bus.zero_q     = zeroReg;

endmodule

// File: tb/tb_mips_ctrl_alu.sv
// tb_mips_ctrl_alu
// Directed test of mips_ctrl_alu. Expected values are hand-computed from the
// decoder tables and the ALU definition.
module tb_mips_ctrl_alu;
  logic clk;
  logic reset;
  int   nCompared;
  int   nMismatched;

  mips_ctrl_alu_if bus ();

  mips_ctrl_alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Controls packed as {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop}.
  function automatic logic [31:0] ctrlVec();
    return {23'd0, bus.regwrite, bus.regdst, bus.alusrc, bus.branch,
            bus.memwrite, bus.memtoreg, bus.jump, bus.aluop};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] funct,
                       input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.funct = funct;
    bus.srca  = a;
    bus.srcb  = b;
    #1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset = 1'b1;
    drive(6'b000000, 6'b100000, 32'd0, 32'd0);
    #2;
    check("reset_aluout_q", bus.aluout_q, 32'd0);
    check("reset_zero_q", {31'd0, bus.zero_q}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1. R-type add
    drive(6'b000000, 6'b100000, 32'd7, 32'd5);
    check("add_ctrl", ctrlVec(), 32'b1_1_0_0_0_0_0_10);
    check("add_alucontrol", {29'd0, bus.alucontrol}, 32'd2);
    check("add_aluout", bus.aluout, 32'd12);
    check("add_zero", {31'd0, bus.zero}, 32'd0);
    @(posedge clk); #1;
    check("add_aluout_q", bus.aluout_q, 32'd12);
    check("add_zero_q", {31'd0, bus.zero_q}, 32'd0);

    // 2. beq equal
    drive(6'b000100, 6'b000000, 32'h1234, 32'h1234);
    check("beq_ctrl", ctrlVec(), 32'b0_0_0_1_0_0_0_01);
    check("beq_alucontrol", {29'd0, bus.alucontrol}, 32'd6);
    check("beq_aluout", bus.aluout, 32'd0);
    check("beq_zero", {31'd0, bus.zero}, 32'd1);
    @(posedge clk); #1;
    check("beq_zero_q", {31'd0, bus.zero_q}, 32'd1);
    check("beq_aluout_q", bus.aluout_q, 32'd0);

    // beq not equal: 9 - 4 = 5
    drive(6'b000100, 6'b000000, 32'd9, 32'd4);
    check("beq_ne_aluout", bus.aluout, 32'd5);
    check("beq_ne_zero", {31'd0, bus.zero}, 32'd0);

    // 3. slt signed
    drive(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1);
    check("slt_alucontrol", {29'd0, bus.alucontrol}, 32'd7);
    check("slt_neg_lt_pos", bus.aluout, 32'd1);
    drive(6'b000000, 6'b101010, 32'h7FFFFFFF, 32'h80000000);
    check("slt_overflow", bus.aluout, 32'd0);
    check("slt_overflow_zero", {31'd0, bus.zero}, 32'd1);

    // other R-type functs
    drive(6'b000000, 6'b100010, 32'd3, 32'd5);
    check("sub_aluout", bus.aluout, 32'hFFFFFFFE);
    drive(6'b000000, 6'b100100, 32'hF0F0_1234, 32'h0FF0_00FF);
    check("and_aluout", bus.aluout, 32'h00F0_0034);
    check("and_alucontrol", {29'd0, bus.alucontrol}, 32'd0);
    drive(6'b000000, 6'b100101, 32'hF000_0001, 32'h0000_0F10);
    check("or_aluout", bus.aluout, 32'hF000_0F11);
    check("or_alucontrol", {29'd0, bus.alucontrol}, 32'd1);

    // 4. lw, sw, addi
    drive(6'b100011, 6'b101010, 32'h100, 32'h8);
    check("lw_ctrl", ctrlVec(), 32'b1_0_1_0_0_1_0_00);
    check("lw_aluout", bus.aluout, 32'h108);
    drive(6'b101011, 6'b100010, 32'h200, 32'h4);
    check("sw_ctrl", ctrlVec(), 32'b0_0_1_0_1_0_0_00);
    check("sw_aluout", bus.aluout, 32'h204);
    drive(6'b001000, 6'b000000, 32'hFFFFFFFF, 32'd1);
    check("addi_ctrl", ctrlVec(), 32'b1_0_1_0_0_0_0_00);
    check("addi_wrap_aluout", bus.aluout, 32'd0);
    check("addi_wrap_zero", {31'd0, bus.zero}, 32'd1);

    // 5. j, undefined op, undefined funct
    drive(6'b000010, 6'b000000, 32'd1, 32'd2);
    check("j_ctrl", ctrlVec(), 32'b0_0_0_0_0_0_1_00);
    drive(6'b111111, 6'b101010, 32'd1, 32'd2);
    check("undef_op_ctrl", ctrlVec(), 32'd0);
    check("undef_op_alucontrol", {29'd0, bus.alucontrol}, 32'd2);
    check("undef_op_aluout", bus.aluout, 32'd3);
    drive(6'b000000, 6'b000000, 32'd10, 32'd20);
    check("undef_funct_alucontrol", {29'd0, bus.alucontrol}, 32'd2);
    check("undef_funct_aluout", bus.aluout, 32'd30);

    // 6. asynchronous reset
    drive(6'b000000, 6'b100000, 32'hDEADBEEF, 32'd0);
    @(posedge clk); #1;
    check("pre_reset_aluout_q", bus.aluout_q, 32'hDEADBEEF);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_aluout_q", bus.aluout_q, 32'd0);
    check("async_reset_zero_q", {31'd0, bus.zero_q}, 32'd0);
    check("reset_comb_aluout", bus.aluout, 32'hDEADBEEF);
    drive(6'b000100, 6'b000000, 32'd5, 32'd5);
    @(posedge clk); #1;
    check("hold_reset_aluout_q", bus.aluout_q, 32'd0);
    check("hold_reset_zero_q", {31'd0, bus.zero_q}, 32'd0);
    check("reset_comb_zero", {31'd0, bus.zero}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    drive(6'b000000, 6'b100000, 32'h1111, 32'h2222);
    check("post_reset_pending_q", bus.aluout_q, 32'd0);
    @(posedge clk); #1;
    check("post_reset_aluout_q", bus.aluout_q, 32'h3333);
    check("post_reset_zero_q", {31'd0, bus.zero_q}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
